// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
//   Round-robin, packet-locked arbiter that shares one AXI-Stream master port
//   between NUM_S AXI-Stream slave ports. In IDLE it picks the first valid
//   port starting at the rotating pointer, registers it as the grant, and in
//   BUSY passes that port straight through until its tlast handshake.
//
// Ports
//   aclk, areset      clock / synchronous active-high reset
//   s_valid/s_ready   per-port handshake
//   s_data/s_keep     per-port beat payload (WORDS_PER_BEAT words) and word keep
//   s_last            per-port end of packet
//   m_valid/m_ready   master handshake
//   m_data/m_keep     master beat payload and word keep
//   m_last            master end of packet
//   m_id              index of the granted port, meaningful while m_valid
//
// Optional build macro AXIS_RR_ARBITER_STATS_EN adds:
//   pkt_count         per-port completed-packet counters (32-bit, wrapping)
//   beat_count        total transferred beats (32-bit, wrapping)

module axis_rr_arbiter #(
  parameter  int NUM_S          = 4,
  parameter  int WORD_WIDTH     = 16,
  parameter  int BUS_WIDTH      = 64,
  parameter  int ID_W           = $clog2(NUM_S),
  localparam int WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH
) (
  input  logic                                                 aclk,
  input  logic                                                 areset,
  input  logic [NUM_S-1:0]                                     s_valid,
  output logic [NUM_S-1:0]                                     s_ready,
  input  logic [NUM_S-1:0][WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] s_data,
  input  logic [NUM_S-1:0][WORDS_PER_BEAT-1:0]                 s_keep,
  input  logic [NUM_S-1:0]                                     s_last,
  output logic                                                 m_valid,
  input  logic                                                 m_ready,
  output logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0]            m_data,
  output logic [WORDS_PER_BEAT-1:0]                            m_keep,
  output logic                                                 m_last,
  output logic [ID_W-1:0]                                      m_id
`ifdef AXIS_RR_ARBITER_STATS_EN
  ,
  output logic [NUM_S-1:0][31:0]                               pkt_count,
  output logic [31:0]                                          beat_count
`endif
);

  localparam int unsigned NUM_S_U = NUM_S;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] ptr_q,   ptr_d;
  logic [ID_W-1:0] pick;
  logic            pick_found;

  // Wrap-around priority search starting at ptr_q.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] cand;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_S_U; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_S_U) idx = idx - NUM_S_U;
      cand = ID_W'(idx);
      if (!pick_found && s_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // Zero-latency pass-through of the granted port while BUSY.
  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    m_last  = 1'b0;
    m_id    = '0;
    if (state_q == BUSY) begin
      m_valid          = s_valid[grant_q];
      m_data           = s_data[grant_q];
      m_keep           = s_keep[grant_q];
      m_last           = s_last[grant_q];
      m_id             = grant_q;
      s_ready[grant_q] = m_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (m_valid && m_ready && m_last) begin
          state_d = IDLE;
          ptr_d   = (grant_q == ID_W'(NUM_S - 1)) ? '0 : grant_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef AXIS_RR_ARBITER_STATS_EN
  logic [NUM_S-1:0][31:0] pkt_count_q, pkt_count_d;
  logic [31:0]            beat_count_q, beat_count_d;

  always_comb begin
    pkt_count_d  = pkt_count_q;
    beat_count_d = beat_count_q;
    if (m_valid && m_ready) begin
      beat_count_d = beat_count_q + 32'd1;
      if (m_last) pkt_count_d[grant_q] = pkt_count_q[grant_q] + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_count_q  <= '0;
      beat_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign beat_count = beat_count_q;
`endif

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin, packet-locked arbiter sharing one AXI-Stream master port between NUM_S AXI-Stream slave ports.
- Grants one requester and forwards its beats until the tlast handshake, then re-arbitrates.
- Sits between multiple stream producers (e.g. per-lane result streams) and a single downstream consumer (DMA / output sink).

Parameters:
- NUM_S, 4, number of slave (requester) ports, >=2.
- WORD_WIDTH, 16, bits per word.
- BUS_WIDTH, 64, bits per beat.
- WORDS_PER_BEAT, BUS_WIDTH/WORD_WIDTH, derived, not overridden.
- ID_W, $clog2(NUM_S), width of grant index.

Ports:
- aclk  in  1  clock; all logic on posedge.
- areset  in  1  synchronous reset, active-high.
- s_valid  in  [NUM_S]  per-port tvalid.
- s_ready  out  [NUM_S]  per-port tready.
- s_data  in  [NUM_S][WORDS_PER_BEAT][WORD_WIDTH]  per-port tdata.
- s_keep  in  [NUM_S][WORDS_PER_BEAT]  per-port tkeep, one bit per word.
- s_last  in  [NUM_S]  per-port tlast.
- m_valid  out  1  master tvalid.
- m_ready  in  1  master tready.
- m_data  out  [WORDS_PER_BEAT][WORD_WIDTH]  master tdata.
- m_keep  out  [WORDS_PER_BEAT]  master tkeep.
- m_last  out  1  master tlast.
- m_id  out  ID_W  index of the granted port; valid while m_valid.

Behaviour:
- Reset: areset is sampled on posedge aclk and is synchronous, active-high. It forces state=IDLE, grant=0, ptr=0. While in IDLE: s_ready=0, m_valid=0, m_data=0, m_keep=0, m_last=0, m_id=0.
- FSM state IDLE:
  - If any s_valid is high, select the first asserted index searching ptr, ptr+1, ... NUM_S-1, 0, ... ptr-1 (wrap-around).
  - Register the selection into grant and move to BUSY next cycle.
  - If no s_valid is high, stay in IDLE.
  - No beat is accepted in IDLE.
- FSM state BUSY:
  - Combinational pass-through of the granted port: m_valid=s_valid[grant], m_data=s_data[grant], m_keep=s_keep[grant], m_last=s_last[grant], m_id=grant.
  - s_ready[grant]=m_ready; all other s_ready=0.
  - Transfer occurs when m_valid && m_ready.
  - On a transfer with m_last=1: next state IDLE, ptr=(grant+1) wrapping NUM_S-1 to 0.
  - On any other transfer, or on a stall, stay in BUSY with grant held. The grant is locked for the whole packet.
- Latency:
  - 1 cycle from s_valid (IDLE) to m_valid, i.e. arbitration bubble.
  - Zero-cycle data/ready path in BUSY.
  - Minimum 1 idle cycle between consecutive packets.
- Fairness: with all ports continuously requesting, grants cycle 0,1,2,...,NUM_S-1,0. A port waits at most NUM_S-1 packets.
- Granted port deasserting s_valid mid-packet: arbiter stays in BUSY with m_valid=0. It does not re-arbitrate until that port's tlast.
- Non-granted ports: s_valid/s_data are ignored; their s_ready is held 0; they never lose data.
- Single-beat packet (s_last on first beat): handshake in cycle N+1 after grant, IDLE in N+2.
- Reset asserted mid-packet: takes effect at the next posedge. The partial packet is truncated downstream, with no m_last. ptr returns to 0.
- m_keep is passed unmodified; partial final beats are allowed.

Optional Feature:
- Macro: AXIS_RR_ARBITER_STATS_EN.
- With the macro defined, extra outputs are added:
  - pkt_count out [NUM_S][31:0]: per-port count of completed packets (m_last handshakes), incremented the cycle after tlast transfer.
  - beat_count out [31:0]: total transferred beats.
  - Both counters clear on areset and wrap at 2^32.
- Without the macro: no counters and no extra ports. Behaviour is otherwise identical.

Test Plan:
- Single port: port 2 sends a 3-beat packet with data 0..11 (4 words/beat), m_ready=1 → m_valid rises 1 cycle after s_valid; m_id=2; beats emerge in order; m_last on beat 3; FSM returns to IDLE; ptr=3.
- All 4 ports each send 2-packet streams continuously after reset → packet grant order is 0,1,2,3,0,1,2,3; no interleaving of beats within a packet.
- Backpressure: randomize m_ready at 20% and s_valid at 5%, with files/streams of 202 words per port → output file contains every port's words contiguously per packet; totals are 808 words; no loss or duplication.
- Wrap/fairness: ptr=3, ports 0 and 3 requesting → port 3 is granted first, then port 0.
- Reset mid-packet: areset pulsed for 1 cycle after beat 2 of a 5-beat packet from port 1 → next cycle all s_ready=0 and m_valid=0; a subsequent request from port 1 is granted with ptr=0 order.
- Stats (macro defined): after 3 packets from port 0 (2, 1 and 4 beats) → pkt_count[0]=3, beat_count=7; others 0.
